// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
//   DW / AW / NREG : data width, register address width, register count
//   req_id_t       : write-back requester identity (ALU or memory load unit)
//   wb_req_t       : one write-back request {valid, rd, data}
package regfile_pkg;

   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int NREG = 16;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_t;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regwb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Owns the pointer recording the most recent
// winner; on a tie the other requester is granted.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> ALU)
//   req[1:0]   : request vector, bit 0 = ALU, bit 1 = MEM
//   accept     : a grant was taken this cycle, pointer moves to the winner
//   gnt[1:0]   : one-hot grant (combinational), zero when nothing requests
//
// State table (pointer `last`)
//   state   | meaning
//   REQ_ALU | ALU won most recently; MEM wins the next tie
//   REQ_MEM | MEM won most recently; ALU wins the next tie
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   req_id_t last_q;
   req_id_t last_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= REQ_ALU;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      last_d = last_q;
      if (accept) begin
         last_d = gnt[1] ? REQ_MEM : REQ_ALU;
      end
   end

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/regwb_arbiter.sv
// Write-back controller for the 16 x 16-bit register file. Shares the single
// write port between the ALU and the load unit with a round-robin valid/ready
// handshake, and keeps a busy scoreboard of registers with writes in flight.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     : ALU write-back request, alu_ready = accept
//   mem_valid/mem_rd/mem_data     : load write-back request, mem_ready = accept
//   issue_valid/issue_rd          : destination of the issuing instruction
//   chk_rs/chk_rt, stall          : decode source addresses, RAW hazard stall
//   busy                          : scoreboard, one bit per register
//   add_Rd/data_wr/regwr          : registered register-file write port
module regwb_arbiter
   import regfile_pkg::wb_req_t;
#(
   parameter int DW   = regfile_pkg::DW,
   parameter int AW   = regfile_pkg::AW,
   parameter int NREG = regfile_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [DW-1:0]   alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_rd,
   input  logic [DW-1:0]   mem_data,
   output logic            mem_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   chk_rs,
   input  logic [AW-1:0]   chk_rt,
   output logic            stall,
   output logic [NREG-1:0] busy,
   output logic [AW-1:0]   add_Rd,
   output logic [DW-1:0]   data_wr,
   output logic            regwr
);

   wb_req_t         alu_req;
   wb_req_t         mem_req;
   wb_req_t         win;
   logic [1:0]      gnt;
   logic            accept;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
   assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({mem_req.valid, alu_req.valid}),
      .accept (accept),
      .gnt    (gnt)
   );

   // Grants are suppressed during reset so nothing is taken while the
   // write port and scoreboard are being cleared.
   assign alu_ready = gnt[0] & ~rst;
   assign mem_ready = gnt[1] & ~rst;
   assign win       = mem_ready ? mem_req : alu_req;
   assign accept    = win.valid & (alu_ready | mem_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         add_Rd  <= '0;
         data_wr <= '0;
         regwr   <= 1'b0;
      end else begin
         regwr <= accept && (win.rd != '0);
         if (accept) begin
            add_Rd  <= win.rd;
            data_wr <= win.data;
         end
      end
   end

   // Set is applied after clear: a newer producer of the same register is
   // still in flight when an older write retires on the same edge.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept) begin
         clr_mask[win.rd] = 1'b1;
      end
      if (issue_valid) begin
         set_mask[issue_rd] = 1'b1;
      end
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy  = busy_q;
   assign stall = busy_q[chk_rs] | busy_q[chk_rt];

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [3:0]  alu_rd = '0;
   logic [15:0] alu_data = '0;
   logic        alu_ready;
   logic        mem_valid = 1'b0;
   logic [3:0]  mem_rd = '0;
   logic [15:0] mem_data = '0;
   logic        mem_ready;
   logic        issue_valid = 1'b0;
   logic [3:0]  issue_rd = '0;
   logic [3:0]  chk_rs = '0;
   logic [3:0]  chk_rt = '0;
   logic        stall;
   logic [15:0] busy;
   logic [3:0]  add_Rd;
   logic [15:0] data_wr;
   logic        regwr;

   regwb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .chk_rs(chk_rs), .chk_rt(chk_rt),
      .stall(stall), .busy(busy), .add_Rd(add_Rd), .data_wr(data_wr), .regwr(regwr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  rd;
      logic [15:0] data;
      logic        we;
   } wb_exp_t;

   wb_exp_t     sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;

   // Reference model state: pending producer requests, tie-break memory,
   // busy set of registers, and a log of grants ('A'/'M').
   bit          a_pend = 0, m_pend = 0;
   logic [3:0]  a_rd = '0, m_rd = '0;
   logic [15:0] a_d = '0, m_d = '0;
   bit          last_mem = 0;
   bit          mbusy[16];
   byte         glog[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [15:0] busy_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = mbusy[i];
      return v;
   endfunction

   // Monitor: after each edge, compare the write port against the scoreboard
   // and the busy vector against the model.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("wb_late", 32'(sb[0].cyc), 32'(cyc));
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("regwr", 32'(regwr), 32'(sb[0].we));
            check("add_Rd", 32'(add_Rd), 32'(sb[0].rd));
            check("data_wr", 32'(data_wr), 32'(sb[0].data));
            void'(sb.pop_front());
         end else begin
            check("regwr_idle", 32'(regwr), 32'd0);
         end
         check("busy", 32'(busy), 32'(busy_vec()));
      end
   end

   task automatic step(input bit r, input bit iv, input logic [3:0] ird,
                       input logic [3:0] rs, input logic [3:0] rt);
      bit exp_a, exp_m;
      wb_exp_t e;
      @(negedge clk);
      rst = r;
      alu_valid = a_pend; alu_rd = a_rd; alu_data = a_d;
      mem_valid = m_pend; mem_rd = m_rd; mem_data = m_d;
      issue_valid = iv; issue_rd = ird; chk_rs = rs; chk_rt = rt;
      #1;
      exp_a = 0; exp_m = 0;
      if (!r) begin
         if (a_pend && m_pend) begin
            if (last_mem) exp_a = 1; else exp_m = 1;
         end else begin
            exp_a = a_pend;
            exp_m = m_pend;
         end
      end
      check("alu_ready", 32'(alu_ready), 32'(exp_a));
      check("mem_ready", 32'(mem_ready), 32'(exp_m));
      check("stall", 32'(stall), 32'(mbusy[rs] | mbusy[rt]));
      if (r) begin
         foreach (mbusy[i]) mbusy[i] = 0;
         last_mem = 0;
         e.cyc = cyc + 1; e.rd = '0; e.data = '0; e.we = 0;
         sb.push_back(e);
      end else begin
         if (exp_a || exp_m) begin
            e.cyc  = cyc + 1;
            e.rd   = exp_m ? m_rd : a_rd;
            e.data = exp_m ? m_d : a_d;
            e.we   = (e.rd != 0);
            sb.push_back(e);
            mbusy[e.rd] = 0;
            last_mem = exp_m;
            glog.push_back(exp_m ? "M" : "A");
            if (exp_m) m_pend = 0; else a_pend = 0;
         end
         if (iv && ird != 0) mbusy[ird] = 1;
      end
   endtask

   initial begin
      string gs;
      // Reset, then idle.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rst_busy", 32'(busy), 32'h0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // ALU only.
      a_pend = 1; a_rd = 4'd3; a_d = 16'hBEEF;
      step(0, 0, 0, 0, 0);
      check("alu_only_ready", 32'(alu_ready), 32'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Both continuously valid after reset: M,A,M,A,M,A.
      step(1, 0, 0, 0, 0);
      glog.delete();
      for (int i = 0; i < 6; i++) begin
         if (!a_pend) begin a_pend = 1; a_rd = 4'd1; a_d = 16'(16'hA000 + i); end
         if (!m_pend) begin m_pend = 1; m_rd = 4'd2; m_d = 16'(16'hD000 + i); end
         step(0, 0, 0, 0, 0);
      end
      gs = "";
      foreach (glog[i]) gs = {gs, string'(glog[i])};
      n_cmp++;
      if (gs != "MAMAMA") begin
         n_bad++;
         $display("FAIL grant_order: got %s expected MAMAMA", gs);
      end
      a_pend = 0; m_pend = 0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Scoreboard hazard on r5.
      step(0, 1, 4'd5, 0, 0);
      step(0, 0, 0, 4'd5, 0);
      check("haz_stall_set", 32'(stall), 32'd1);
      step(0, 0, 0, 4'd5, 0);
      m_pend = 1; m_rd = 4'd5; m_d = 16'h5555;
      step(0, 0, 0, 4'd5, 0);
      step(0, 0, 0, 4'd5, 0);
      check("haz_stall_clr", 32'(stall), 32'd0);
      check("haz_busy5_clr", 32'(busy[5]), 32'd0);
      // Same-edge set and clear: set wins.
      step(0, 1, 4'd5, 0, 0);
      m_pend = 1; m_rd = 4'd5; m_d = 16'h6666;
      step(0, 1, 4'd5, 0, 0);
      step(0, 0, 0, 0, 4'd5);
      check("same_edge_busy5", 32'(busy[5]), 32'd1);
      m_pend = 1; m_rd = 4'd5; m_d = 16'h7777;
      step(0, 0, 0, 0, 0);

      // r0 write and issue to r0.
      m_pend = 1; m_rd = 4'd0; m_d = 16'h1234;
      step(0, 1, 4'd0, 0, 0);
      check("r0_ready", 32'(mem_ready), 32'd1);
      step(0, 0, 0, 0, 0);
      check("r0_busy", 32'(busy), 32'h0);
      check("r0_regwr", 32'(regwr), 32'd0);

      // Reset mid-traffic with busy[7] set.
      step(0, 1, 4'd7, 0, 0);
      a_pend = 1; a_rd = 4'd9; a_d = 16'h0909;
      m_pend = 1; m_rd = 4'd10; m_d = 16'h0A0A;
      step(0, 0, 0, 0, 0);
      if (!a_pend) begin a_pend = 1; a_rd = 4'd9; a_d = 16'h0999; end
      if (!m_pend) begin m_pend = 1; m_rd = 4'd10; m_d = 16'h0AAA; end
      step(1, 1, 4'd7, 0, 0);
      step(0, 0, 0, 0, 0);
      check("post_rst_mem_first", 32'(mem_ready), 32'd1);
      step(0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (!a_pend && $urandom_range(0, 2) != 0) begin
            a_pend = 1; a_rd = 4'($urandom_range(0, 15)); a_d = 16'($urandom);
         end
         if (!m_pend && $urandom_range(0, 2) != 0) begin
            m_pend = 1; m_rd = 4'($urandom_range(0, 15)); m_d = 16'($urandom);
         end
         step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      a_pend = 0; m_pend = 0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
